i2c_master_arbiter: RTL
=======================

# i2c_master_arbiter

Round-robin arbiter and transaction sequencer that shares one I2C master FSM between up to NREQ requesters. It grants one requester at a time and drives the master's enable and control inputs: fsm_select_ low, control_reg = read or write command, reset_register = reset command. It tracks the master's busy flag to detect transaction completion and recovers a hung master by issuing the reset command. It sits between the system-side requesters and the I2C master, in the master's clock domain.

## Interface
- NREQ, 4, number of requesters (2..8)
- TIMEOUT_CYC, 1024, max cycles in LAUNCH or RUN before recovery (power of 2, ≤ 65536)
- RST_HOLD, 4, cycles the reset command is held during recovery (1..15)
- clk  in  1  system clock, rising edge
- rst_  in  1  reset, asynchronous, active-low
- req  in  NREQ  per-requester transaction request, level, held until done
- rd_wr  in  NREQ  per-requester direction (1 = read, 0 = write), sampled at grant
- gnt  out  NREQ  one-hot grant, registered
- done  out  NREQ  one-cycle completion pulse to the granted requester
- err  out  1  one-cycle pulse coincident with done when the transaction was aborted by timeout
- master_busy  in  1  high while the master FSM is outside IDLE
- fsm_select_  out  1  master enable, active-low
- control_reg  out  8  0xAA read, 0x55 write, 0x00 idle
- reset_register  out  8  0xCC reset command, else 0x00

## Operation
- States: IDLE, LAUNCH, RUN, RELEASE, RECOVER.
- IDLE:
  - If any req bit is set, pick the first set bit at or after ptr, wrapping modulo NREQ.
  - Register gnt, fsm_select_=0 and control_reg (0xAA if rd_wr[winner], else 0x55).
  - Go to LAUNCH and clear the timeout counter.
- LAUNCH: wait for master_busy=1, then go to RUN and clear the counter.
- RUN: wait for master_busy=0, then go to RELEASE.
- RELEASE (one cycle):
  - Pulse done[winner], and err if entered from RECOVER.
  - fsm_select_=1, control_reg=0x00, gnt=0.
  - ptr = winner+1 mod NREQ. Go to IDLE.
- RECOVER:
  - Entered when the counter reaches TIMEOUT_CYC-1 in LAUNCH or RUN.
  - reset_register=0xCC and fsm_select_=0 for RST_HOLD cycles, then reset_register=0x00 and go to RELEASE.
- Outputs stay stable while granted. req or rd_wr changes after grant are ignored.
- Deasserting req mid-transaction does not abort; done still pulses.
- The requester must drop req in the cycle after done. A req still high when IDLE evaluates is treated as a new transaction, but is served after other pending requesters because ptr has advanced.
- Only one gnt bit is ever high. done and err are never high outside RELEASE.
- Timeout counter is log2(TIMEOUT_CYC) bits and saturates (never wraps).

## Timing
- Reset values: state IDLE, gnt=0, done=0, err=0, fsm_select_=1, control_reg=0x00, reset_register=0x00, ptr=0, counter=0.
- Reset mid-transaction: all outputs return to reset values immediately (asynchronous). No done pulse is issued.
- Grant latency: req sampled high at edge n → gnt, fsm_select_ and control_reg valid after edge n.
- done latency: master_busy sampled low in RUN at edge m → done high for the cycle after edge m+1.
- Minimum gap between grants: one idle cycle. After RELEASE, the next gnt appears no earlier than the second edge.
- master_busy high already in IDLE, or a glitch in LAUNCH: not special-cased. LAUNCH advances on the first sampled high.

## Configuration
- I2C_ARB_TIMEOUT_EN defined:
  - Timeout counter and RECOVER state are present.
  - err can pulse.
- I2C_ARB_TIMEOUT_EN undefined:
  - Counter and RECOVER are removed. LAUNCH and RUN wait indefinitely.
  - reset_register is tied to 0x00 and err is tied to 0.
  - TIMEOUT_CYC and RST_HOLD are unused.

## Test plan
- Single write: req=4'b0001, rd_wr=0 → gnt=0001 and control_reg=0x55 one edge later. Busy held high 20 cycles then low → done=0001 for one cycle, err=0, control_reg=0x00.
- Round-robin: req=4'b1011 held continuously, each transaction acked → grant order 0,1,3,0,1,3. No requester is granted twice in a row while others wait.
- Read direction: req[2]=1, rd_wr[2]=1 → control_reg=0xAA. Toggling rd_wr[2] mid-RUN leaves control_reg at 0xAA.
- Timeout (macro on, TIMEOUT_CYC=16, RST_HOLD=4): master_busy never rises → reset_register=0xCC for exactly 4 cycles starting 16 cycles after grant, then done and err pulse together, ptr advances.
- Async reset mid-RUN: rst_ low → gnt=0, fsm_select_=1, control_reg=0x00 immediately, no done. After release, a pending req[0] is granted first (ptr=0).
- Macro off, busy stuck high: gnt stays asserted for 5000 cycles, reset_register stays 0x00, err never pulses.

Source files
------------

// File: rtl/i2c_master_arbiter_if.sv
// Bus between the requester-side arbiter and the shared I2C master FSM.
// The master modport is the arbiter's view; slave is the requester/master-FSM side.
interface i2c_master_arbiter_if #(
    parameter int NREQ = 4
);
    logic [NREQ-1:0] req;
    logic [NREQ-1:0] rd_wr;
    logic [NREQ-1:0] gnt;
    logic [NREQ-1:0] done;
    logic            err;
    logic            master_busy;
    logic            fsm_select_;
    logic [7:0]      control_reg;
    logic [7:0]      reset_register;

    modport master (
        input  req, rd_wr, master_busy,
        output gnt, done, err, fsm_select_, control_reg, reset_register
    );

    modport slave (
        output req, rd_wr, master_busy,
        input  gnt, done, err, fsm_select_, control_reg, reset_register
    );
endinterface

// File: rtl/i2c_master_arbiter.sv
// Round-robin arbiter sequencing NREQ requesters onto one I2C master FSM.
// Optional hung-master recovery (timeout + reset command) under I2C_ARB_TIMEOUT_EN.
module i2c_master_arbiter #(
    parameter int NREQ        = 4,
    parameter int TIMEOUT_CYC = 1024,
    parameter int RST_HOLD    = 4
) (
    input  logic                  clk,
    input  logic                  rst_,
    i2c_master_arbiter_if.master  bus
);
    localparam int              PW       = $clog2(NREQ);
    localparam logic [NREQ-1:0] GNT_ONE  = NREQ'(1'b1);
    localparam logic [7:0]      CMD_RD   = 8'hAA;
    localparam logic [7:0]      CMD_WR   = 8'h55;
    localparam logic [7:0]      CMD_NONE = 8'h00;

`ifdef I2C_ARB_TIMEOUT_EN
    localparam int          CW        = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYC - 1);
    localparam logic [3:0]    HOLD_LAST = 4'(RST_HOLD - 1);
    localparam logic [7:0]    CMD_RST   = 8'hCC;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LAUNCH  = 3'd1,
        ST_RUN     = 3'd2,
        ST_RELEASE = 3'd3,
        ST_RECOVER = 3'd4
    } state_t;

    logic [CW-1:0] cnt_r, cnt_s;
    logic [3:0]    hold_r, hold_s;
    logic          abort_r, abort_s;
    logic          err_r, err_s;
    logic [7:0]    rstreg_r, rstreg_s;
`else
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LAUNCH  = 3'd1,
        ST_RUN     = 3'd2,
        ST_RELEASE = 3'd3
    } state_t;

    logic unused_cfg_s;
    assign unused_cfg_s = ^{TIMEOUT_CYC[0], RST_HOLD[0]};
`endif

    state_t          state_r, state_s;
    logic [PW-1:0]   ptr_r, ptr_s;
    logic [PW-1:0]   winner_r, winner_s;
    logic [NREQ-1:0] gnt_r, gnt_s;
    logic [NREQ-1:0] done_r, done_s;
    logic            fsel_r, fsel_s;
    logic [7:0]      ctrl_r, ctrl_s;
    logic [PW-1:0]   pick_s, cand_s;
    logic            found_s;

    // Round-robin search: first requesting index at or after ptr, wrapping.
    always_comb begin
        pick_s  = '0;
        cand_s  = '0;
        found_s = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (int'(ptr_r) + i >= NREQ) begin
                cand_s = PW'(int'(ptr_r) + i - NREQ);
            end else begin
                cand_s = PW'(int'(ptr_r) + i);
            end
            if (!found_s && bus.req[cand_s]) begin
                found_s = 1'b1;
                pick_s  = cand_s;
            end else begin
                found_s = found_s;
            end
        end
    end

    // Next-state and next-output logic for the sequencer.
    always_comb begin
        state_s  = state_r;
        ptr_s    = ptr_r;
        winner_s = winner_r;
        gnt_s    = gnt_r;
        done_s   = '0;
        fsel_s   = fsel_r;
        ctrl_s   = ctrl_r;
`ifdef I2C_ARB_TIMEOUT_EN
        cnt_s    = cnt_r;
        hold_s   = hold_r;
        abort_s  = abort_r;
        err_s    = 1'b0;
        rstreg_s = rstreg_r;
`endif
        case (state_r)
            ST_IDLE: begin
                if (found_s) begin
                    winner_s = pick_s;
                    gnt_s    = GNT_ONE << pick_s;
                    fsel_s   = 1'b0;
                    ctrl_s   = bus.rd_wr[pick_s] ? CMD_RD : CMD_WR;
                    state_s  = ST_LAUNCH;
`ifdef I2C_ARB_TIMEOUT_EN
                    cnt_s    = '0;
                    abort_s  = 1'b0;
`endif
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_LAUNCH: begin
                if (bus.master_busy) begin
                    state_s = ST_RUN;
`ifdef I2C_ARB_TIMEOUT_EN
                    cnt_s   = '0;
                end else if (cnt_r == CNT_LAST) begin
                    state_s  = ST_RECOVER;
                    rstreg_s = CMD_RST;
                    hold_s   = 4'd0;
                end else begin
                    cnt_s = cnt_r + CW'(1);
`else
                end else begin
                    state_s = ST_LAUNCH;
`endif
                end
            end
            ST_RUN: begin
                // Completion wins over a timeout reached in the same cycle.
                if (!bus.master_busy) begin
                    state_s = ST_RELEASE;
`ifdef I2C_ARB_TIMEOUT_EN
                end else if (cnt_r == CNT_LAST) begin
                    state_s  = ST_RECOVER;
                    rstreg_s = CMD_RST;
                    hold_s   = 4'd0;
                end else begin
                    cnt_s = cnt_r + CW'(1);
`else
                end else begin
                    state_s = ST_RUN;
`endif
                end
            end
            ST_RELEASE: begin
                done_s  = gnt_r;
                gnt_s   = '0;
                fsel_s  = 1'b1;
                ctrl_s  = CMD_NONE;
                ptr_s   = (winner_r == PW'(NREQ - 1)) ? '0 : winner_r + PW'(1);
                state_s = ST_IDLE;
`ifdef I2C_ARB_TIMEOUT_EN
                err_s   = abort_r;
`endif
            end
`ifdef I2C_ARB_TIMEOUT_EN
            ST_RECOVER: begin
                if (hold_r == HOLD_LAST) begin
                    rstreg_s = CMD_NONE;
                    abort_s  = 1'b1;
                    state_s  = ST_RELEASE;
                end else begin
                    hold_s = hold_r + 4'd1;
                end
            end
`endif
            default: begin
                state_s = ST_IDLE;
                gnt_s   = '0;
                fsel_s  = 1'b1;
                ctrl_s  = CMD_NONE;
`ifdef I2C_ARB_TIMEOUT_EN
                rstreg_s = CMD_NONE;
`endif
            end
        endcase
    end

    // State and registered outputs, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state_r  <= ST_IDLE;
            ptr_r    <= '0;
            winner_r <= '0;
            gnt_r    <= '0;
            done_r   <= '0;
            fsel_r   <= 1'b1;
            ctrl_r   <= CMD_NONE;
`ifdef I2C_ARB_TIMEOUT_EN
            cnt_r    <= '0;
            hold_r   <= 4'd0;
            abort_r  <= 1'b0;
            err_r    <= 1'b0;
            rstreg_r <= CMD_NONE;
`endif
        end else begin
            state_r  <= state_s;
            ptr_r    <= ptr_s;
            winner_r <= winner_s;
            gnt_r    <= gnt_s;
            done_r   <= done_s;
            fsel_r   <= fsel_s;
            ctrl_r   <= ctrl_s;
`ifdef I2C_ARB_TIMEOUT_EN
            cnt_r    <= cnt_s;
            hold_r   <= hold_s;
            abort_r  <= abort_s;
            err_r    <= err_s;
            rstreg_r <= rstreg_s;
`endif
        end
    end

    assign bus.gnt         = gnt_r;
    assign bus.done        = done_r;
    assign bus.fsm_select_ = fsel_r;
    assign bus.control_reg = ctrl_r;
`ifdef I2C_ARB_TIMEOUT_EN
    assign bus.err            = err_r;
    assign bus.reset_register = rstreg_r;
`else
    assign bus.err            = 1'b0;
    assign bus.reset_register = CMD_NONE;
`endif
endmodule
